// File: rtl/id_decode_pipe_pkg.sv
// Shared decode definitions: opcodes, funct7 values, format enum and the decoded bundle.
package id_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    // XLEN-wide fields (pc, imm) travel beside this struct so it stays width-independent.
    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [6:0] funct7;
        fmt_e       fmt;
        logic       rs1_used;
        logic       rs2_used;
        logic       rd_we;
        logic       illegal;
        logic       muldiv;
    } dec_t;

endpackage

// File: rtl/id_decode_pipe_if.sv
// Fetch-side request and EX-side decoded bundle of the ID stage; slave = decode stage.
interface id_decode_pipe_if #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [ILEN-1:0] in_inst;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rd;
    logic [2:0]      out_funct3;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [6:0]      out_funct7;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_rs1_used;
    logic            out_rs2_used;
    logic            out_rd_we;
    logic            out_illegal;
    logic            out_muldiv;

    modport master (
        output flush, in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_funct3, out_rs1,
               out_rs2, out_funct7, out_imm, out_fmt, out_rs1_used, out_rs2_used,
               out_rd_we, out_illegal, out_muldiv
    );

    modport slave (
        input  flush, in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rd, out_funct3, out_rs1,
               out_rs2, out_funct7, out_imm, out_fmt, out_rs1_used, out_rs2_used,
               out_rd_we, out_illegal, out_muldiv
    );
endinterface

// File: rtl/id_decode_pipe_imm_gen.sv
// Combinational format classification and sign-extended immediate extraction.
module id_imm_gen
    import id_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt
);
    logic [31:0] raw;

    always_comb begin
        fmt = FMT_R;
        case (inst[6:0])
            OPC_LUI, OPC_AUIPC:                 fmt = FMT_U;
            OPC_JAL:                            fmt = FMT_J;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM,
            OPC_MISC_MEM, OPC_SYSTEM:           fmt = FMT_I;
            OPC_STORE:                          fmt = FMT_S;
            OPC_BRANCH:                         fmt = FMT_B;
            default:                            fmt = FMT_R;
        endcase
    end

    // Every format is assembled as a sign-extended 32-bit value, then widened signed.
    always_comb begin
        raw = '0;
        case (fmt)
            FMT_I:   raw = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   raw = {inst[31:12], 12'b0};
            FMT_J:   raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: raw = '0;
        endcase
        imm = XLEN'($signed(raw));
    end
endmodule

// File: rtl/id_decode_pipe.sv
// RV32I/RV64I decode stage: registered output plus 1-entry skid buffer, flushable.
// Optional M-extension decode enabled by defining ID_DECODE_MULDIV_EN.
module id_decode_pipe
    import id_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ILEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    id_decode_pipe_if.slave   io
);
    dec_t            dec;
    fmt_e            fmt;
    logic [XLEN-1:0] imm;

    dec_t            out_q, skid_q;
    logic [XLEN-1:0] out_pc_q, out_imm_q, skid_pc_q, skid_imm_q;
    logic            out_valid_q, skid_valid_q;

    logic [31:0] inst;
    assign inst = io.in_inst[31:0];

    id_imm_gen #(.XLEN(XLEN)) u_imm (
        .inst (inst),
        .imm  (imm),
        .fmt  (fmt)
    );

    always_comb begin
        dec          = '0;
        dec.opcode   = inst[6:0];
        dec.rd       = inst[11:7];
        dec.funct3   = inst[14:12];
        dec.rs1      = inst[19:15];
        dec.rs2      = inst[24:20];
        dec.funct7   = inst[31:25];
        dec.fmt      = fmt;
        dec.rs1_used = (fmt != FMT_U) && (fmt != FMT_J);
        dec.rs2_used = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
        dec.rd_we    = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J);

        case (inst[6:0])
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE: ;
            OPC_MISC_MEM: dec.rd_we = 1'b0;
            OPC_SYSTEM:   if (inst[14:12] == 3'b000) dec.rd_we = 1'b0;
            OPC_BRANCH:   if (inst[14:13] == 2'b01) dec.illegal = 1'b1;
            OPC_OP: begin
                if (inst[31:25] == F7_ALT) begin
                    if (inst[14:12] != 3'b000 && inst[14:12] != 3'b101) dec.illegal = 1'b1;
                end else if (inst[31:25] == F7_MULDIV) begin
`ifdef ID_DECODE_MULDIV_EN
                    dec.muldiv = 1'b1;
`else
                    dec.illegal = 1'b1;
`endif
                end else if (inst[31:25] != F7_BASE) begin
                    dec.illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                // RV64 shifts use a 6-bit shamt, leaving only inst[31:26] as the funct field.
                if (XLEN == 64) begin
                    if (inst[14:12] == 3'b001 && inst[31:26] != 6'b000000) dec.illegal = 1'b1;
                    if (inst[14:12] == 3'b101 && inst[31:26] != 6'b000000 &&
                        inst[31:26] != 6'b010000) dec.illegal = 1'b1;
                end else begin
                    if (inst[14:12] == 3'b001 && inst[31:25] != F7_BASE) dec.illegal = 1'b1;
                    if (inst[14:12] == 3'b101 && inst[31:25] != F7_BASE &&
                        inst[31:25] != F7_ALT) dec.illegal = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase

        if (inst[1:0] != 2'b11) dec.illegal = 1'b1;
        if (inst[11:7] == 5'd0) dec.rd_we = 1'b0;
        if (dec.illegal) begin
            dec.rd_we    = 1'b0;
            dec.rs1_used = 1'b0;
            dec.rs2_used = 1'b0;
        end
    end

    logic accept, out_free;
    assign accept   = io.in_valid & ~skid_valid_q;
    assign out_free = ~out_valid_q | io.out_ready;

    // in_ready depends only on skid state, so out_ready never reaches it combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            out_pc_q     <= '0;
            out_imm_q    <= '0;
            skid_q       <= '0;
            skid_pc_q    <= '0;
            skid_imm_q   <= '0;
        end else if (io.flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_pc_q     <= skid_pc_q;
                out_imm_q    <= skid_imm_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (accept) begin
                out_q       <= dec;
                out_pc_q    <= io.in_pc;
                out_imm_q   <= imm;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (accept) begin
            skid_q       <= dec;
            skid_pc_q    <= io.in_pc;
            skid_imm_q   <= imm;
            skid_valid_q <= 1'b1;
        end
    end

    assign io.in_ready     = ~skid_valid_q;
    assign io.out_valid    = out_valid_q;
    assign io.out_pc       = out_pc_q;
    assign io.out_imm      = out_imm_q;
    assign io.out_opcode   = out_q.opcode;
    assign io.out_rd       = out_q.rd;
    assign io.out_funct3   = out_q.funct3;
    assign io.out_rs1      = out_q.rs1;
    assign io.out_rs2      = out_q.rs2;
    assign io.out_funct7   = out_q.funct7;
    assign io.out_fmt      = out_q.fmt;
    assign io.out_rs1_used = out_q.rs1_used;
    assign io.out_rs2_used = out_q.rs2_used;
    assign io.out_rd_we    = out_q.rd_we;
    assign io.out_illegal  = out_q.illegal;
    assign io.out_muldiv   = out_q.muldiv;
endmodule

// File: tb/tb_id_decode_pipe.sv
// Directed bench for id_decode_pipe: decode fields, skid backpressure, flush, async reset.
module tb_id_decode_pipe;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    id_decode_pipe_if #(.XLEN(32), .ILEN(32)) bus ();

    id_decode_pipe #(.XLEN(32), .ILEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one instruction for exactly one edge; results are sampled 1ns after that edge.
    task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        bus.in_pc    = pc;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_inst   = '0;
        bus.out_ready = 1'b1;
        #2;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready",  bus.in_ready, 1);
        chk("rst_imm",       bus.out_imm, 0);
        chk("rst_rd",        bus.out_rd, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // addi x1,x0,-1
        issue(32'hFFF00093, 32'h100);
        chk("addi_valid", bus.out_valid, 1);
        chk("addi_rd",    bus.out_rd, 1);
        chk("addi_imm",   bus.out_imm, 32'hFFFFFFFF);
        chk("addi_fmt",   bus.out_fmt, 1);
        chk("addi_rd_we", bus.out_rd_we, 1);
        chk("addi_rs1u",  bus.out_rs1_used, 1);
        chk("addi_rs2u",  bus.out_rs2_used, 0);
        chk("addi_ill",   bus.out_illegal, 0);
        chk("addi_pc",    bus.out_pc, 32'h100);

        // beq x1,x2,-4
        issue(32'hFE208EE3, 32'h104);
        chk("beq_imm",   bus.out_imm, 32'hFFFFFFFC);
        chk("beq_fmt",   bus.out_fmt, 3);
        chk("beq_rs1",   bus.out_rs1, 1);
        chk("beq_rs2",   bus.out_rs2, 2);
        chk("beq_rd_we", bus.out_rd_we, 0);
        chk("beq_rs2u",  bus.out_rs2_used, 1);
        chk("beq_pc",    bus.out_pc, 32'h104);

        // sw x2,8(x1)
        issue(32'h0020A423, 32'h108);
        chk("sw_imm",   bus.out_imm, 32'h8);
        chk("sw_fmt",   bus.out_fmt, 2);
        chk("sw_rd_we", bus.out_rd_we, 0);

        // jal x1,+8
        issue(32'h008000EF, 32'h10C);
        chk("jal_imm",   bus.out_imm, 32'h8);
        chk("jal_fmt",   bus.out_fmt, 5);
        chk("jal_rd_we", bus.out_rd_we, 1);
        chk("jal_rs1u",  bus.out_rs1_used, 0);

        // sub x0,x1,x2 : rd=0 suppresses write
        issue(32'h40208033, 32'h110);
        chk("sub_fmt",   bus.out_fmt, 0);
        chk("sub_ill",   bus.out_illegal, 0);
        chk("sub_rd_we", bus.out_rd_we, 0);
        chk("sub_f7",    bus.out_funct7, 7'b0100000);

        // funct7=0100000 with funct3=010 is not a valid OP
        issue(32'h4020A033, 32'h114);
        chk("opalt_ill",  bus.out_illegal, 1);
        chk("opalt_rs1u", bus.out_rs1_used, 0);
        // branch funct3=010 reserved
        issue(32'h0020A063, 32'h118);
        chk("br010_ill", bus.out_illegal, 1);
        // lui x5 (also verifies U immediate)
        issue(32'h123452B7, 32'h11C);
        chk("lui_imm", bus.out_imm, 32'h12345000);
        chk("lui_fmt", bus.out_fmt, 4);

        // mul x3,x1,x2
        issue(32'h022081B3, 32'h120);
`ifdef ID_DECODE_MULDIV_EN
        chk("mul_ill",    bus.out_illegal, 0);
        chk("mul_muldiv", bus.out_muldiv, 1);
        chk("mul_rd_we",  bus.out_rd_we, 1);
`else
        chk("mul_ill",    bus.out_illegal, 1);
        chk("mul_muldiv", bus.out_muldiv, 0);
        chk("mul_rd_we",  bus.out_rd_we, 0);
`endif
        @(posedge clk);
        #1;
        chk("idle_valid", bus.out_valid, 0);

        // Backpressure: lui held in output, addi into skid
        bus.out_ready = 1'b0;
        issue(32'h123452B7, 32'h200);
        chk("bp1_valid", bus.out_valid, 1);
        chk("bp1_ready", bus.in_ready, 1);
        issue(32'hFFF00093, 32'h204);
        chk("bp2_ready", bus.in_ready, 0);
        chk("bp2_imm",   bus.out_imm, 32'h12345000);
        @(posedge clk);
        #1;
        chk("bp_hold_imm", bus.out_imm, 32'h12345000);
        chk("bp_hold_pc",  bus.out_pc, 32'h200);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_drain_valid", bus.out_valid, 1);
        chk("bp_drain_imm",   bus.out_imm, 32'hFFFFFFFF);
        chk("bp_drain_pc",    bus.out_pc, 32'h204);
        chk("bp_drain_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        chk("bp_empty", bus.out_valid, 0);

        // Flush with skid full and a new instruction offered
        bus.out_ready = 1'b0;
        issue(32'h123452B7, 32'h300);
        issue(32'hFFF00093, 32'h304);
        chk("fl_pre_ready", bus.in_ready, 0);
        @(negedge clk);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_inst  = 32'h008000EF;
        bus.in_pc    = 32'h308;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl_valid", bus.out_valid, 0);
        chk("fl_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("fl_after_valid", bus.out_valid, 0);

        // Async reset while stalled with skid full
        bus.out_ready = 1'b0;
        issue(32'h123452B7, 32'h400);
        issue(32'hFFF00093, 32'h404);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", bus.out_valid, 0);
        chk("ar_imm",   bus.out_imm, 0);
        chk("ar_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("ar_no_pulse", bus.out_valid, 0);

        // All-zero word is illegal (inst[1:0] != 11)
        issue(32'h00000000, 32'h500);
        chk("zero_valid", bus.out_valid, 1);
        chk("zero_ill",   bus.out_illegal, 1);
        chk("zero_rd_we", bus.out_rd_we, 0);
        chk("zero_imm",   bus.out_imm, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
